fetch_decode_stage: RTL
=======================

Name: fetch_decode_stage

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage MIPS pipeline; sits directly upstream of decode.
- Consumes the hazard unit's StallF/StallD and decode's branch/jump resolution (PCSrcD, JumpD, PCBranchD).
- Owns the PC, drives a request/ready instruction-memory port and delivers InstrD/PCPlus4D/ValidD to decode, inserting bubbles on memory wait, redirect or flush.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, instruction word injected into InstrD on bubble/flush.

Ports:
clk  input  1  pipeline clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
StallF  input  1  hold PC (from hazard unit)
StallD  input  1  hold IF/ID register (from hazard unit)
PCSrcD  input  1  branch taken, resolved in decode
JumpD  input  1  jump instruction in decode
PCBranchD  input  32  branch target from decode
imem_req  output  1  instruction fetch request
imem_addr  output  32  fetch address (= PCF)
imem_rdata  input  32  instruction word, valid when imem_ready
imem_ready  input  1  fetch completes this cycle (may be same cycle as request)
PCF  output  32  current fetch PC
InstrD  output  32  instruction in decode
PCPlus4D  output  32  PC+4 of InstrD
ValidD  output  1  InstrD is a real instruction (0 = bubble)

Behaviour:
- Reset (async, reset_n=0): PCF=RESET_PC, InstrD=NOP_INSTR, PCPlus4D=0, ValidD=0, state=RUN, redirect_pc=0, imem_req=0. Reset mid-DRAIN abandons the outstanding fetch.
- imem_req=1 whenever reset_n=1; imem_addr=PCF combinationally.
- Handshake: once a request is presented, imem_addr is held stable until the cycle imem_ready=1. Transfer completes on a clock edge with imem_req & imem_ready.
- Jump target = {PCPlus4D[31:28], InstrD[25:0], 2'b00}. Redirect = (JumpD | PCSrcD) & ValidD & ~StallD. Target priority: JumpD over PCSrcD.
- Redirect while StallD=1 is ignored; decode re-presents it after the stall.
- Next-PC: redirect ? target : PCF+4 (32-bit wrap, carry discarded).
- FSM state RUN:
  - imem_ready & redirect: PCF<=target; fetched word discarded.
  - imem_ready & ~redirect & ~StallF: PCF<=PCF+4.
  - imem_ready & StallF & ~redirect: PCF holds; word discarded and refetched.
  - ~imem_ready & redirect: redirect_pc<=target; PCF holds; go to DRAIN.
  - ~imem_ready & ~redirect: hold.
- FSM state DRAIN (wrong-path request outstanding):
  - Address held. On imem_ready: discard data, PCF<=redirect_pc, go to RUN.
  - Further redirects cannot occur: ValidD=0 in DRAIN.
- IF/ID update, priority order:
  - StallD: hold all three.
  - Redirect: InstrD<=NOP_INSTR, ValidD<=0 (flush).
  - RUN & imem_ready & ~StallF: InstrD<=imem_rdata, PCPlus4D<=PCF+4, ValidD<=1.
  - Otherwise bubble: InstrD<=NOP_INSTR, ValidD<=0, PCPlus4D holds.
- Latency: one cycle from completed fetch to InstrD. Zero-wait memory sustains 1 instruction/cycle.
- Redirect penalty: 1 bubble, plus the remaining wait cycles if caught in DRAIN.

Test Plan:
- Zero-wait memory with imem_ready=1 and imem_rdata=addr-tagged: after reset, PCF sequence 0,4,8,C. InstrD follows one cycle later with ValidD=1 from cycle 2 and PCPlus4D=PCF_prev+4.
- StallF=StallD=1 for 2 cycles at PCF=8: PCF stays 8 and InstrD/PCPlus4D/ValidD are held. On release PCF goes 8→C and the stream has no gap or duplicate.
- PCSrcD=1 with PCBranchD=0x40, ValidD=1, imem_ready=1: next edge PCF=0x40 and ValidD=0. Next InstrD is word@0x40 with PCPlus4D=0x44.
- JumpD with InstrD[25:0]=0x10 and PCPlus4D=0x1000_0008: PCF becomes 0x1000_0040. With PCSrcD also 1 and PCBranchD=0x80, the jump still wins.
- imem_ready=0 for 3 cycles, branch to 0x100 in the first of those cycles: imem_addr is held at the old PC until ready, then PCF=0x100. ValidD=0 throughout, and the first valid InstrD is word@0x100.
- reset_n pulsed low mid-DRAIN: all outputs return to reset values asynchronously, state=RUN, and fetching restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_decode_stage.sv
// Fetch stage and IF/ID register: owns the PC and the instruction-memory request/ready port.
// A completed fetch reaches InstrD one cycle later. Memory waits, stalls and redirects insert bubbles.
module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        PCSrcD,
  input  logic        JumpD,
  input  logic [31:0] PCBranchD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t      state, state_next;
  logic [31:0] redirect_pc, redirect_pc_next;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] target;
  logic        redirect;
  logic        fetch_take;

  assign imem_req    = reset_n;
  assign imem_addr   = PCF;
  assign pc_plus4    = PCF + 32'd4;
  assign jump_target = {PCPlus4D[31:28], InstrD[25:0], 2'b00};
  assign target      = JumpD ? jump_target : PCBranchD;
  // A stalled decode re-presents its branch later, so it must not redirect now.
  assign redirect    = (JumpD | PCSrcD) & ValidD & ~StallD;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN;
      PCF         <= RESET_PC;
      redirect_pc <= 32'h0;
    end else begin
      state       <= state_next;
      PCF         <= pc_next;
      redirect_pc <= redirect_pc_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (!imem_ready && redirect) state_next = DRAIN;
      DRAIN:   if (imem_ready) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // The in-flight address must stay put until ready, so a redirect during a wait is parked.
  always_comb begin
    pc_next          = PCF;
    redirect_pc_next = redirect_pc;
    fetch_take       = 1'b0;
    case (state)
      RUN: begin
        if (imem_ready) begin
          if (redirect) begin
            pc_next = target;
          end else if (!StallF) begin
            pc_next    = pc_plus4;
            fetch_take = 1'b1;
          end
        end else if (redirect) begin
          redirect_pc_next = target;
        end
      end
      DRAIN: begin
        if (imem_ready) pc_next = redirect_pc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      InstrD   <= NOP_INSTR;
      PCPlus4D <= 32'h0;
      ValidD   <= 1'b0;
    end else if (StallD) begin
      InstrD   <= InstrD;
      PCPlus4D <= PCPlus4D;
      ValidD   <= ValidD;
    end else if (redirect) begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end else if (fetch_take) begin
      InstrD   <= imem_rdata;
      PCPlus4D <= pc_plus4;
      ValidD   <= 1'b1;
    end else begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end
  end

endmodule
